// File: rtl/time_display_scan_if.sv
// Digit inputs and display pin bundle for the time display scanner.
// Master drives the BCD digits and blink mask; slave drives the display pins.
interface time_display_scan_if;
  logic [3:0] hr_tens;
  logic [3:0] hr_ones;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] blink_mask;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       dp_n;

  modport master (
    output hr_tens, hr_ones, min_tens, min_ones, blink_mask,
    input  an_n, seg_n, dp_n
  );

  modport slave (
    input  hr_tens, hr_ones, min_tens, min_ones, blink_mask,
    output an_n, seg_n, dp_n
  );
endinterface

// File: rtl/time_display_scan.sv
// Four-digit multiplexed seven-segment scanner with frame snapshot, LZ blanking, blink and colon.
// Outputs registered, 1-cycle latency from scan state; free-running with no backpressure.
module time_display_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 125,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  time_display_scan_if.slave bus
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [BW-1:0] r_bcnt;
  logic          r_blink_on;
  logic [3:0]    r_snap [4];
  logic [3:0]    r_snap_mask;
  logic [3:0]    r_an_n;
  logic [6:0]    r_seg_n;
  logic          r_dp_n;

  logic          w_slot_end;
  logic          w_frame_end;
  logic [3:0]    w_digit;
  logic          w_blank;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    w_slot_end  = (r_cnt == CNT_LAST);
    w_frame_end = w_slot_end && (r_idx == 2'd3);
    w_digit     = r_snap[r_idx];
    w_blank     = (r_snap_mask[r_idx] && !r_blink_on) ||
                  (LZ_BLANK && (r_idx == 2'd3) && (w_digit == 4'd0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_bcnt      <= '0;
      r_blink_on  <= 1'b1;
      r_snap_mask <= 4'd0;
      for (int i = 0; i < 4; i++) r_snap[i] <= 4'd0;
      r_an_n      <= 4'b1111;
      r_seg_n     <= 7'h7F;
      r_dp_n      <= 1'b1;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
      if (w_slot_end) r_idx <= r_idx + 2'd1;

      // Snapshot and blink phase change together so a frame never mixes old and new state.
      if (w_frame_end) begin
        r_snap[0]   <= bus.min_ones;
        r_snap[1]   <= bus.min_tens;
        r_snap[2]   <= bus.hr_ones;
        r_snap[3]   <= bus.hr_tens;
        r_snap_mask <= bus.blink_mask;
        if (r_bcnt == BLINK_LAST) begin
          r_bcnt     <= '0;
          r_blink_on <= ~r_blink_on;
        end else begin
          r_bcnt <= r_bcnt + 1'b1;
        end
      end

      // First cycle of each slot keeps all anodes off to hide segment transitions.
      r_an_n  <= (r_cnt == '0) ? 4'b1111 : ~(4'b0001 << r_idx);
      r_seg_n <= w_blank ? 7'h7F : f_decode(w_digit);
      r_dp_n  <= ~((r_idx == 2'd2) && r_blink_on);
    end
  end

  assign bus.an_n  = r_an_n;
  assign bus.seg_n = r_seg_n;
  assign bus.dp_n  = r_dp_n;
endmodule

// File: doc/time_display_scan.md
# time_display_scan

Multiplexed four-digit seven-segment scanner for the alarm clock. It reads the BCD time digits from the hour and minute digit registers and drives them onto a common-anode, time-multiplexed display. It adds frame-synchronous snapshotting, leading-zero blanking, edit-mode digit blinking and a blinking colon. It is the reader side of the digit registers' Q outputs and sits between the time/alarm registers and the board display pins.

## Interface

Parameters:
- REFRESH_DIV, default 50000: clock cycles per digit slot; legal range ≥ 2.
- BLINK_FRAMES, default 125: full scan frames per blink half-period; legal range ≥ 1.
- LZ_BLANK, default 1: when 1, hour-tens digit value 0 is blanked.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- hr_tens, input, 4: BCD hour tens (0–2 in normal use).
- hr_ones, input, 4: BCD hour ones.
- min_tens, input, 4: BCD minute tens.
- min_ones, input, 4: BCD minute ones.
- blink_mask, input, 4: per-digit blink enable; bit i maps to slot i.
- an_n, output, 4: active-low digit enables; bit 0 = min_ones, 1 = min_tens, 2 = hr_ones, 3 = hr_tens.
- seg_n, output, 7: active-low segments, {g,f,e,d,c,b,a}.
- dp_n, output, 1: active-low decimal point, used as the colon.

## Operation

- Slot counter cnt counts 0..REFRESH_DIV-1, increments every cycle and wraps to 0.
- Slot index idx (0..3) advances 0→1→2→3→0 on the cycle where cnt = REFRESH_DIV-1.
- frame_end = (cnt = REFRESH_DIV-1) and (idx = 3).
- Snapshot: on frame_end, all four digit inputs and blink_mask are latched into snapshot registers. Input changes mid-frame never affect the current frame.
- Blink: blink counter counts frames 0..BLINK_FRAMES-1 on frame_end. blink_on toggles when it wraps, so each visible or blank phase lasts exactly BLINK_FRAMES frames.
- Digit select uses the snapshot digit for idx.
- The digit is blanked (seg_n = 7'h7F) if either condition holds:
  - snap_blink_mask[idx] = 1 and blink_on = 0;
  - idx = 3, the digit is 0, and LZ_BLANK = 1.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 = 0111111 (dash: only g lit)
- Colon: dp_n = 0 only during slot idx = 2 with blink_on = 1; otherwise 1.
- Ghost guard: while cnt = 0, an_n = 4'b1111, regardless of idx.
- A blanked digit still has its an_n bit driven low outside the guard cycle. Only seg_n and dp_n go dark.

## Timing

- an_n, seg_n and dp_n are registered. Each reflects the cnt, idx, snapshot and blink_on values from the previous cycle (1-cycle latency).
- Reset values while reset_n = 0, applied asynchronously with no clock required:
  - an_n = 4'b1111, seg_n = 7'h7F, dp_n = 1
  - cnt = 0, idx = 0, blink counter = 0, blink_on = 1
  - all snapshot registers = 0
- First rising edge after reset release gives an_n = 1111 (guard, cnt was 0). The second edge gives an_n = 1110.
- The first frame after reset displays the zeroed snapshot: blank, 0, 0, 0 with LZ_BLANK = 1. Live inputs appear from the frame after the first frame_end.
- A snapshot taken on frame_end is displayed starting with the next idx = 0 slot.
- Frame length = 4·REFRESH_DIV cycles. Blink half-period = 4·REFRESH_DIV·BLINK_FRAMES cycles.
- reset_n asserted mid-slot turns all outputs off immediately. All counters restart from 0 on release.

## Test plan

All scenarios use REFRESH_DIV = 4, BLINK_FRAMES = 2, LZ_BLANK = 1.
- **Reset:** hold reset_n = 0 for 3 cycles, then release. Required: outputs read 1111/7F/1 during reset; edge 1 gives an_n = 1111; edge 2 gives an_n = 1110 with seg_n = 1000000.
- **12:34 display:** drive inputs 1,2,3,4 and wait one frame. Required, per slot:
  - an_n = 1110 with seg_n = 0011001 (4)
  - an_n = 1101 with seg_n = 0110000 (3)
  - an_n = 1011 with seg_n = 0100100 (2) and dp_n = 0
  - an_n = 0111 with seg_n = 1111001 (1)
  - an_n = 1111 for exactly 1 cycle at the start of each slot.
- **Tear-free snapshot:** change min_ones from 4 to 7 at cnt = 2 of slot 1. Required: the slot-0 display stays 4 until the next frame, then shows 1111000.
- **Leading zero and invalid BCD:** hr_tens = 0 gives seg_n = 7F while an_n = 0111. hr_tens = 12 gives seg_n = 0111111.
- **Blink:** set blink_mask = 0011. Required: slots 0–1 alternate 2 frames visible, 2 frames blank (32 cycles each), and dp_n on slot 2 follows the same phase. Slots 2–3 stay visible throughout.
- **Reset mid-frame:** pull reset_n low at idx = 2, cnt = 3. Required: outputs go 1111/7F/1 before the next clock edge, and the post-release sequence matches the reset scenario.
